// File: rtl/pvt_scan_ctrl.sv
// Scan controller for the ring-oscillator process sensor: steps one shared sensor
// through the masked channels and keeps a per-channel result bank for host readback.
//
// state | meaning
// IDLE  | waiting for start
// SEEK  | find lowest masked channel >= pointer
// ARM   | ps_en pulse to the sensor, timeout counter cleared
// WAIT  | waiting for ps_valid rising edge or timeout
// STORE | write ps_data into result bank
// DONE  | end of pass, done pulse
module pvt_scan_ctrl #(
    parameter int NCH       = 16,
    parameter int TO_MARGIN = 16,
    parameter int TO_W      = 12
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic              stop,
    input  logic [NCH-1:0]    ch_mask,
    input  logic [9:0]        win,
    input  logic              continuous,
    output logic              busy,
    output logic              done,
    output logic [NCH-1:0]    res_vld,
    output logic [NCH-1:0]    res_err,
    input  logic [3:0]        rd_addr,
    output logic [15:0]       rd_data,
    output logic              ps_en,
    output logic [3:0]        ps_sel,
    output logic [9:0]        ps_count,
    input  logic              ps_valid,
    input  logic [15:0]       ps_data
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SEEK  = 3'd1;
    localparam logic [2:0] S_ARM   = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_STORE = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    logic [2:0]      state_q, state_d;
    logic [4:0]      ptr_q, ptr_d;
    logic [NCH-1:0]  mask_q, mask_d;
    logic            cont_q, cont_d;
    logic [TO_W-1:0] to_q, to_d;
    logic            ps_en_q, ps_en_d;
    logic [3:0]      ps_sel_q, ps_sel_d;
    logic [9:0]      ps_count_q, ps_count_d;
    logic            ps_valid_q;
    logic [NCH-1:0]  vld_q, vld_d;
    logic [NCH-1:0]  err_q, err_d;
    // Bank is always 16 deep; entries at or above NCH are never written and read as 0.
    logic [15:0]     res_q [16];
    logic            res_we;
    logic [15:0]     res_wdata;

    logic            seek_hit;
    logic [3:0]      seek_idx;
    logic [4:0]      ptr_next;
    logic [TO_W-1:0] to_inc;
    logic [TO_W-1:0] to_limit;
    logic            valid_rise;

    assign ptr_next   = {1'b0, ps_sel_q} + 5'd1;
    assign to_inc     = to_q + TO_W'(1);
    assign to_limit   = TO_W'(ps_count_q) + TO_W'(TO_MARGIN);
    assign valid_rise = ps_valid & ~ps_valid_q;

    always_comb begin
        seek_hit = 1'b0;
        seek_idx = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (mask_q[i] && (5'(i) >= ptr_q)) begin
                seek_hit = 1'b1;
                seek_idx = 4'(i);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        mask_d     = mask_q;
        cont_d     = cont_q;
        to_d       = to_q;
        ps_en_d    = 1'b0;
        ps_sel_d   = ps_sel_q;
        ps_count_d = ps_count_q;
        vld_d      = vld_q;
        err_d      = err_q;
        res_we     = 1'b0;
        res_wdata  = ps_data;
        case (state_q)
            S_IDLE: begin
                if (start && !stop) begin
                    mask_d     = ch_mask;
                    ps_count_d = win;
                    cont_d     = continuous;
                    vld_d      = vld_q & ~ch_mask;
                    err_d      = err_q & ~ch_mask;
                    ptr_d      = '0;
                    state_d    = S_SEEK;
                end
            end
            S_SEEK: begin
                if (seek_hit) begin
                    ps_sel_d = seek_idx;
                    ps_en_d  = 1'b1;
                    state_d  = S_ARM;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_ARM: begin
                to_d    = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                to_d = to_inc;
                if (valid_rise) begin
                    state_d = S_STORE;
                end else if (to_inc == to_limit) begin
                    err_d[ps_sel_q] = 1'b1;
                    res_we          = 1'b1;
                    res_wdata       = 16'hFFFF;
                    ptr_d           = ptr_next;
                    state_d         = S_SEEK;
                end
            end
            S_STORE: begin
                res_we          = 1'b1;
                vld_d[ps_sel_q] = 1'b1;
                ptr_d           = ptr_next;
                state_d         = S_SEEK;
            end
            S_DONE: begin
                if (cont_q) begin
                    ptr_d   = '0;
                    vld_d   = vld_q & ~mask_q;
                    err_d   = err_q & ~mask_q;
                    state_d = S_SEEK;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Abort keeps everything already captured; nothing from this cycle lands.
        if (stop && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            ps_en_d = 1'b0;
            res_we  = 1'b0;
            vld_d   = vld_q;
            err_d   = err_q;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            mask_q     <= '0;
            cont_q     <= 1'b0;
            to_q       <= '0;
            ps_en_q    <= 1'b0;
            ps_sel_q   <= '0;
            ps_count_q <= '0;
            ps_valid_q <= 1'b0;
            vld_q      <= '0;
            err_q      <= '0;
            for (int i = 0; i < 16; i++) res_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            mask_q     <= mask_d;
            cont_q     <= cont_d;
            to_q       <= to_d;
            ps_en_q    <= ps_en_d;
            ps_sel_q   <= ps_sel_d;
            ps_count_q <= ps_count_d;
            ps_valid_q <= ps_valid;
            vld_q      <= vld_d;
            err_q      <= err_d;
            if (res_we) res_q[ps_sel_q] <= res_wdata;
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);
    assign res_vld  = vld_q;
    assign res_err  = err_q;
    assign rd_data  = res_q[rd_addr];
    assign ps_en    = ps_en_q;
    assign ps_sel   = ps_sel_q;
    assign ps_count = ps_count_q;
endmodule

// File: doc/pvt_scan_ctrl.md
# pvt_scan_ctrl

Scan controller for the ring-oscillator process sensor macro. It sequences one shared sensor instance through a programmable set of `sel` channels, one measurement per channel, and stores each 16-bit result in a per-channel register bank for the host to read. It sits between the PVT register interface (start/stop/config, readback) and the `psensor` wrapper, and is the only driver of that wrapper's `en`, `sel` and `count` inputs.

## Interface
- `NCH`, 16: number of sensor channels (`sel` values 0..NCH-1); fixed ≤16.
- `TO_MARGIN`, 16: extra cycles beyond the window before a measurement is declared timed out.
- `TO_W`, 12: timeout counter width; must hold 1023+TO_MARGIN.

Ports:
- `clk`  in  1  single clock for controller and sensor wrapper.
- `rstn`  in  1  asynchronous active-low reset.
- `start`  in  1  one-cycle scan request; accepted only in IDLE.
- `stop`  in  1  abort request, honoured in every state.
- `ch_mask`  in  NCH  channels to scan; latched on accepted `start`.
- `win`  in  10  measurement window; latched on accepted `start`, drives `ps_count`.
- `continuous`  in  1  latched on `start`; 1 = rescan forever until `stop`.
- `busy`  out  1  high whenever state ≠ IDLE.
- `done`  out  1  one-cycle pulse at the end of each full pass.
- `res_vld`  out  NCH  per-channel "result captured this pass" bits.
- `res_err`  out  NCH  per-channel timeout bits.
- `rd_addr`  in  4  readback channel index.
- `rd_data`  out  16  combinational read of result[`rd_addr`]; 0 if `rd_addr` ≥ NCH.
- `ps_en`  out  1  sensor enable, registered, one-cycle pulse.
- `ps_sel`  out  4  sensor channel select, registered.
- `ps_count`  out  10  sensor window, registered.
- `ps_valid`  in  1  sensor ready (level; cleared by the sensor after it sees `en`).
- `ps_data`  in  16  sensor result.

## Operation
- States: IDLE, SEEK, ARM, WAIT, STORE, DONE.
- IDLE: on `start`, latch `ch_mask`, `win` and `continuous`; clear `res_vld`/`res_err` bits of masked channels (unmasked bits keep their values); set scan pointer to 0; go to SEEK.
- SEEK: find the lowest masked channel ≥ pointer.
  - If found: load `ps_sel`; go to ARM.
  - If none: go to DONE. An empty mask goes straight to DONE without touching the sensor.
- ARM: assert `ps_en` for this single cycle; clear the timeout counter; go to WAIT.
- WAIT: `ps_valid_q` is `ps_valid` registered every cycle in all states.
  - Capture condition: rising edge (`ps_valid & ~ps_valid_q`). On this edge, go to STORE.
  - A stale high level from the previous measurement is ignored until it falls and rises again.
  - Timeout counter increments each cycle. When it reaches `win`+TO_MARGIN, set `res_err[sel]`, write 16'hFFFF to result[sel], and go to SEEK with pointer = sel+1.
- STORE: write `ps_data` to result[sel]; set `res_vld[sel]`; pointer = sel+1; go to SEEK.
- DONE: pulse `done`.
  - If `continuous`: pointer = 0, clear the masked `res_vld`/`res_err` bits, go to SEEK.
  - Otherwise: go to IDLE.
- `stop`, in any non-IDLE state:
  - next state is IDLE and `ps_en` is 0 next cycle;
  - no `done` pulse;
  - stored results and flags are retained.
  - If `stop` and `start` are asserted together in IDLE, `stop` wins and `start` is ignored.
- `start` while busy is ignored. Config inputs are sampled only at an accepted `start`.
- `ps_sel` and `ps_count` stay stable from ARM through STORE.
- Pointer arithmetic: a pointer of NCH means "none left"; it never wraps inside a pass.

## Timing
- Reset values:
  - state IDLE;
  - `busy`, `done`, `ps_en` = 0;
  - `ps_sel`, `ps_count` = 0;
  - `res_vld`, `res_err` = 0;
  - all results = 0; `ps_valid_q` = 0.
  - Reset mid-scan returns to these values immediately (asynchronous).
- `busy` rises the cycle after an accepted `start`.
- With the behavioural sensor (2-FF `en` sync), for ARM in cycle T:
  - `ps_valid` rises at T+4+`win`;
  - STORE occurs at T+5+`win`;
  - the next channel's ARM occurs at T+7+`win`.
- `done` pulses one cycle after the last SEEK. `busy` falls the cycle after `done` in single-shot mode.
- `rd_data` has zero latency from `rd_addr`. A read during STORE of the same channel returns the old value; the new value appears the next cycle.

## Test plan
- Reset, then `start` with `ch_mask`=16'h0005, `win`=10 and behavioural sensor → two `ps_en` pulses with `ps_sel`=0 then 2; `rd_data`(0)=`rd_data`(2)=16'h00FF; `res_vld`=16'h0005; exactly one `done`; `busy` low afterwards.
- `ch_mask`=0 → `done` pulses within 2 cycles of `start`; `ps_en` never asserted.
- Sensor model with `ps_valid` tied low, `win`=4, mask 16'h0002 → timeout after 20 cycles in WAIT; `res_err`=16'h0002; result[1]=16'hFFFF; `done` pulses.
- `continuous`=1, mask 16'h8001 → repeated `done` pulses with period 2×(7+`win`)+2 cycles; `stop` mid-WAIT → `busy` low next cycle, `ps_en` stays 0, no further `done`.
- `start` pulsed while busy, and `start` with `stop` asserted in the same cycle → both ignored; scan sequence unchanged; no new scan.
- Assert `rstn` low during WAIT → all outputs at reset values in the same cycle; a fresh `start` afterwards completes normally.
